// File: rtl/cpu_pkg.sv
// Shared encodings for the execute-stage multiply/divide unit.
package cpu_pkg;

  // Multiply/divide operation select. Bit 0 set means unsigned.
  // Bit 1 set means divide.
  typedef enum logic [1:0] {
    OP_MULT  = 2'b00,
    OP_MULTU = 2'b01,
    OP_DIV   = 2'b10,
    OP_DIVU  = 2'b11
  } md_op_e;

  // Sequencer states, one encoding per state.
  typedef enum logic [1:0] {
    ST_IDLE  = 2'b00,
    ST_RUN   = 2'b01,
    ST_FIXUP = 2'b10
  } md_state_e;

endpackage

// File: rtl/md_datapath.sv
// Iterative multiply/divide core.
// Operands are turned into magnitudes when an operation starts, so the core
// always runs unsigned arithmetic, one bit per step. The final result is
// sign-corrected combinationally, and the top samples it in the FIXUP cycle.
// MULT uses shift-add, LSB first. Each step adds the multiplicand to the
// upper half when the current multiplier bit is set, then shifts right.
// DIV uses restoring division. Each step shifts left and trial-subtracts the
// divisor from the upper half. When the result is not negative, the step
// keeps it and shifts a 1 into the quotient.
module md_datapath
  import cpu_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load,
  input  logic             step,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic [WIDTH-1:0] hi_res,
  output logic [WIDTH-1:0] lo_res
);

  localparam int AW = 2 * WIDTH + 1;

  // acc_q holds the partial product or remainder in the upper WIDTH+1 bits.
  // It holds the multiplier or the dividend/quotient in the lower WIDTH bits.
  logic [AW-1:0]    acc_q, acc_d;
  logic [WIDTH-1:0] dvs_q;      // multiplicand or divisor magnitude
  logic             is_div_q;
  logic             neg_q_q;    // negate product or quotient
  logic             neg_r_q;    // negate remainder (sign of dividend)
  logic             dz_q;       // divide by zero

  logic             signed_op;
  logic             a_neg, b_neg;
  logic [WIDTH-1:0] a_mag, b_mag;
  logic [WIDTH:0]   mul_upper;
  logic [AW-1:0]    div_shl;
  logic [WIDTH+1:0] div_diff;

  logic [2*WIDTH-1:0] prod, prod_s;
  logic [WIDTH-1:0]   quo, rem;

  // Operand magnitudes and signs for the operation being started.
  always_comb begin
    signed_op = ~op[0];
    a_neg     = signed_op & a[WIDTH-1];
    b_neg     = signed_op & b[WIDTH-1];
    a_mag     = a_neg ? -a : a;
    b_mag     = b_neg ? -b : b;
  end

  // One iteration of either shift-add multiply or restoring divide.
  always_comb begin
    mul_upper = acc_q[0] ? ({1'b0, acc_q[2*WIDTH-1:WIDTH]} + {1'b0, dvs_q})
                         : acc_q[2*WIDTH:WIDTH];
    div_shl   = {acc_q[AW-2:0], 1'b0};
    div_diff  = {1'b0, div_shl[2*WIDTH:WIDTH]} - {2'b00, dvs_q};
    acc_d     = acc_q;
    if (load) begin
      acc_d = {{(WIDTH+1){1'b0}}, a_mag};
    end else if (step) begin
      if (is_div_q) begin
        if (!div_diff[WIDTH+1]) begin
          acc_d = {div_diff[WIDTH:0], div_shl[WIDTH-1:1], 1'b1};
        end else begin
          acc_d = div_shl;
        end
      end else begin
        acc_d = {1'b0, mul_upper, acc_q[WIDTH-1:1]};
      end
    end
  end

  // Accumulator and captured operation attributes.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc_q    <= '0;
      dvs_q    <= '0;
      is_div_q <= 1'b0;
      neg_q_q  <= 1'b0;
      neg_r_q  <= 1'b0;
      dz_q     <= 1'b0;
    end else begin
      acc_q <= acc_d;
      if (load) begin
        dvs_q    <= b_mag;
        is_div_q <= op[1];
        neg_q_q  <= a_neg ^ b_neg;
        neg_r_q  <= a_neg;
        dz_q     <= (b == '0);
      end
    end
  end

  // Sign fixup. A divide by zero forces an all-ones quotient. Its remainder
  // is |a| with the sign of a restored, which gives back a.
  always_comb begin
    prod   = acc_q[2*WIDTH-1:0];
    prod_s = neg_q_q ? -prod : prod;
    quo    = acc_q[WIDTH-1:0];
    rem    = acc_q[2*WIDTH-1:WIDTH];
    if (is_div_q) begin
      lo_res = dz_q ? {WIDTH{1'b1}} : (neg_q_q ? -quo : quo);
      hi_res = neg_r_q ? -rem : rem;
    end else begin
      lo_res = prod_s[WIDTH-1:0];
      hi_res = prod_s[2*WIDTH-1:WIDTH];
    end
  end

endmodule

// File: rtl/execute_muldiv.sv
// Execute-stage HI/LO unit. It sequences the iterative multiply/divide core,
// owns the architectural HI/LO registers and raises a pipeline stall.
// Handshake: start is taken only in IDLE with flush low. Operands are
// captured at that edge. done pulses for one cycle when HI/LO have just been
// written. While busy is high, any start/mt/mf request raises Stall_MD, and
// start/mt requests are dropped.
module execute_muldiv
  import cpu_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int CNTW  = $clog2(WIDTH) + 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             flush,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             mthi,
  input  logic             mtlo,
  input  logic             mfhi,
  input  logic             mflo,
  output logic [WIDTH-1:0] rd_data,
  output logic             busy,
  output logic             done,
  output logic             Stall_MD,
  output logic [1:0]       dbg_state
);

  md_state_e        state_q, state_d;
  logic [CNTW-1:0]  cnt_q, cnt_d;
  logic [WIDTH-1:0] hi_q, hi_d, lo_q, lo_d;
  logic             done_q, done_d;

  logic             start_acc;
  logic             last_iter;
  logic [WIDTH-1:0] hi_res, lo_res;

  assign start_acc = (state_q == ST_IDLE) & start & ~flush;
  assign last_iter = (cnt_q == CNTW'(WIDTH - 1));

  md_datapath #(
    .WIDTH(WIDTH)
  ) u_core (
    .clk    (clk),
    .rst_n  (rst_n),
    .load   (start_acc),
    .step   (state_q == ST_RUN),
    .op     (op),
    .a      (a),
    .b      (b),
    .hi_res (hi_res),
    .lo_res (lo_res)
  );

  // Next state and iteration counter. Flush aborts RUN or FIXUP at once.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      ST_IDLE: begin
        if (start_acc) begin
          state_d = ST_RUN;
          cnt_d   = '0;
        end
      end
      ST_RUN: begin
        cnt_d = cnt_q + 1'b1;
        if (flush) begin
          state_d = ST_IDLE;
          cnt_d   = '0;
        end else if (last_iter) begin
          state_d = ST_FIXUP;
          cnt_d   = '0;
        end
      end
      ST_FIXUP: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  // HI/LO writes. A result is written from FIXUP unless flush is high then.
  // mthi/mtlo write only in IDLE, and a start accepted in the same cycle
  // takes precedence over them.
  always_comb begin
    hi_d   = hi_q;
    lo_d   = lo_q;
    done_d = 1'b0;
    if (state_q == ST_FIXUP) begin
      if (!flush) begin
        hi_d   = hi_res;
        lo_d   = lo_res;
        done_d = 1'b1;
      end
    end else if ((state_q == ST_IDLE) && !start_acc) begin
      if (mthi) hi_d = a;
      if (mtlo) lo_d = a;
    end
  end

  // State, counter, HI/LO and done registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      hi_q    <= '0;
      lo_q    <= '0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
      done_q  <= done_d;
    end
  end

  assign busy      = (state_q != ST_IDLE);
  assign done      = done_q;
  assign Stall_MD  = busy & (start | mfhi | mflo | mthi | mtlo);
  assign rd_data   = mfhi ? hi_q : lo_q;
  assign dbg_state = state_q;

endmodule

// File: tb/tb_execute_muldiv.sv
// Directed bench for execute_muldiv (WIDTH=32).
module tb_execute_muldiv;
  import cpu_pkg::*;

  localparam int W = 32;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         flush = 1'b0;
  logic         start = 1'b0;
  logic [1:0]   op = 2'b00;
  logic [W-1:0] a = '0;
  logic [W-1:0] b = '0;
  logic         mthi = 1'b0;
  logic         mtlo = 1'b0;
  logic         mfhi = 1'b0;
  logic         mflo = 1'b0;
  logic [W-1:0] rd_data;
  logic         busy;
  logic         done;
  logic         Stall_MD;
  logic [1:0]   dbg_state;

  int checks = 0;
  int errors = 0;
  int cyc_cnt = 0;
  int n0 = 0;

  execute_muldiv #(.WIDTH(W)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .flush     (flush),
    .start     (start),
    .op        (op),
    .a         (a),
    .b         (b),
    .mthi      (mthi),
    .mtlo      (mtlo),
    .mfhi      (mfhi),
    .mflo      (mflo),
    .rd_data   (rd_data),
    .busy      (busy),
    .done      (done),
    .Stall_MD  (Stall_MD),
    .dbg_state (dbg_state)
  );

  // Clock and edge counter
  always #5 clk = ~clk;
  always @(posedge clk) cyc_cnt <= cyc_cnt + 1;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(negedge clk);
  endtask

  // Present an operation for one edge, ending in cycle 1.
  task automatic do_start(input logic [1:0] o, input logic [W-1:0] x, input logic [W-1:0] y);
    op = o; a = x; b = y; start = 1'b1;
    n0 = cyc_cnt;
    step();
    start = 1'b0;
  endtask

  // Wait for done with a bound. Returns the cycle index relative to the start edge.
  task automatic wait_done(output int lat);
    int k = 0;
    while (!done && k < 200) begin
      step();
      k++;
    end
    lat = cyc_cnt - n0;
  endtask

  task automatic read_hilo(output logic [W-1:0] hi, output logic [W-1:0] lo);
    mfhi = 1'b1; #1 hi = rd_data; mfhi = 1'b0;
    mflo = 1'b1; #1 lo = rd_data; mflo = 1'b0;
  endtask

  task automatic count_done(input int n, output int seen);
    seen = 0;
    for (int i = 0; i < n; i++) begin
      step();
      if (done) seen++;
    end
  endtask

  // Run one operation to completion and check latency and HI/LO.
  task automatic run_op(input string tag, input logic [1:0] o, input logic [W-1:0] x,
                        input logic [W-1:0] y, input logic [W-1:0] exp_hi,
                        input logic [W-1:0] exp_lo);
    int lat;
    logic [W-1:0] hi, lo;
    do_start(o, x, y);
    wait_done(lat);
    check({tag, "_lat"}, lat, W + 2);
    check({tag, "_busy_at_done"}, busy, 1'b0);
    read_hilo(hi, lo);
    check({tag, "_hi"}, hi, exp_hi);
    check({tag, "_lo"}, lo, exp_lo);
    step();
    check({tag, "_done_pulse"}, done, 1'b0);
  endtask

  initial begin
    int lat;
    int seen;
    logic [W-1:0] hi, lo;

    // Reset state
    #2;
    check("rst_busy", busy, 1'b0);
    check("rst_done", done, 1'b0);
    check("rst_state", dbg_state, ST_IDLE);
    check("rst_stall", Stall_MD, 1'b0);
    read_hilo(hi, lo);
    check("rst_hi", hi, 32'h0);
    check("rst_lo", lo, 32'h0);
    step();
    rst_n = 1'b1;
    step();

    // MULTU 7 x 6. Also check busy in cycle 1.
    do_start(OP_MULTU, 32'd7, 32'd6);
    check("multu_busy_c1", busy, 1'b1);
    check("multu_state_c1", dbg_state, ST_RUN);
    wait_done(lat);
    check("multu_lat", lat, 34);
    check("multu_busy_at_done", busy, 1'b0);
    read_hilo(hi, lo);
    check("multu_hi", hi, 32'h0);
    check("multu_lo", lo, 32'h0000002A);
    step();
    check("multu_done_pulse", done, 1'b0);

    run_op("mult_neg", OP_MULT, -32'sd3, 32'd5, 32'hFFFFFFFF, 32'hFFFFFFF1);
    run_op("div_neg", OP_DIV, -32'sd7, 32'd2, 32'hFFFFFFFF, 32'hFFFFFFFD);
    run_op("div_negdivisor", OP_DIV, 32'd7, -32'sd2, 32'h00000001, 32'hFFFFFFFD);
    run_op("divu_zero", OP_DIVU, 32'd7, 32'd0, 32'h00000007, 32'hFFFFFFFF);
    run_op("div_zero_neg", OP_DIV, -32'sd5, 32'd0, 32'hFFFFFFFB, 32'hFFFFFFFF);
    run_op("div_ovf", OP_DIV, 32'h80000000, 32'hFFFFFFFF, 32'h00000000, 32'h80000000);
    run_op("mult_minmin", OP_MULT, 32'h80000000, 32'h80000000, 32'h40000000, 32'h00000000);
    run_op("multu_max", OP_MULTU, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h00000001);
    run_op("divu_basic", OP_DIVU, 32'd100, 32'd7, 32'd2, 32'd14);

    // mthi, then a MULTU flushed in cycle 10
    a = 32'h1234; mthi = 1'b1;
    step();
    mthi = 1'b0;
    read_hilo(hi, lo);
    check("mthi_hi", hi, 32'h1234);
    check("mthi_lo_kept", lo, 32'd14);
    do_start(OP_MULTU, 32'd3, 32'd4);
    while (cyc_cnt < n0 + 10) step();
    flush = 1'b1;
    step();
    flush = 1'b0;
    check("flush_busy", busy, 1'b0);
    check("flush_state", dbg_state, ST_IDLE);
    count_done(40, seen);
    check("flush_no_done", seen, 0);
    read_hilo(hi, lo);
    check("flush_hi", hi, 32'h1234);
    check("flush_lo", lo, 32'd14);

    // mthi and mtlo together
    a = 32'hCAFE; mthi = 1'b1; mtlo = 1'b1;
    step();
    mthi = 1'b0; mtlo = 1'b0;
    read_hilo(hi, lo);
    check("mtboth_hi", hi, 32'hCAFE);
    check("mtboth_lo", lo, 32'hCAFE);

    // A start coincident with mtlo wins. The stale LO is readable while busy.
    mtlo = 1'b1;
    do_start(OP_MULTU, 32'd9, 32'd2);
    mtlo = 1'b0;
    mflo = 1'b1; #1;
    check("mf_busy_stall", Stall_MD, 1'b1);
    check("mf_busy_stale", rd_data, 32'hCAFE);
    mflo = 1'b0; #1;
    check("busy_no_req_stall", Stall_MD, 1'b0);
    wait_done(lat);
    check("startmt_lat", lat, 34);
    read_hilo(hi, lo);
    check("startmt_hi", hi, 32'h0);
    check("startmt_lo", lo, 32'd18);

    // A start, mflo or mthi while busy is stalled and ignored.
    do_start(OP_DIVU, 32'd100, 32'd7);
    step(); step();
    start = 1'b1; op = OP_MULTU; a = 32'd5; b = 32'd5; mflo = 1'b1; mthi = 1'b1;
    #1;
    check("stall_flag", Stall_MD, 1'b1);
    check("stall_stale_lo", rd_data, 32'd18);
    step();
    start = 1'b0; mflo = 1'b0; mthi = 1'b0;
    wait_done(lat);
    check("stall_lat", lat, 34);
    read_hilo(hi, lo);
    check("stall_hi", hi, 32'd2);
    check("stall_lo", lo, 32'd14);
    count_done(40, seen);
    check("stall_second_ignored", seen, 0);

    // Flush in the final FIXUP cycle suppresses the write.
    do_start(OP_MULTU, 32'd2, 32'd3);
    while (cyc_cnt < n0 + W + 1) step();
    check("fixup_state", dbg_state, ST_FIXUP);
    flush = 1'b1;
    step();
    flush = 1'b0;
    check("fixup_flush_done", done, 1'b0);
    check("fixup_flush_busy", busy, 1'b0);
    read_hilo(hi, lo);
    check("fixup_flush_hi", hi, 32'd2);
    check("fixup_flush_lo", lo, 32'd14);

    // Reset in the middle of RUN
    do_start(OP_MULT, 32'd2, 32'd3);
    step(); step(); step(); step();
    rst_n = 1'b0;
    #1;
    check("mrst_busy", busy, 1'b0);
    check("mrst_state", dbg_state, ST_IDLE);
    read_hilo(hi, lo);
    check("mrst_hi", hi, 32'h0);
    check("mrst_lo", lo, 32'h0);
    step();
    rst_n = 1'b1;
    count_done(50, seen);
    check("mrst_no_done", seen, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
